// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between an instruction-fetch requester
// and a data requester, with one outstanding transaction at a time.
module mem_arbiter #(
    parameter int DATA_PRIO = 1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        i_read,
    input  logic [31:0] i_address,
    output logic [31:0] i_rdata,
    output logic        i_resp,

    input  logic        d_read,
    input  logic        d_write,
    input  logic [3:0]  d_byte_enable,
    input  logic [31:0] d_address,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_resp,

    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  mem_byte_enable,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp
);

    typedef enum logic [1:0] {
        IDLE,
        I_BUSY,
        D_BUSY
    } state_t;

    state_t      state_q, state_d;
    logic        last_d_q, last_d_d;   // 1 when the most recent grant went to data
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        write_q, write_d;

    logic        d_req;
    logic        grant_d;

    // Arbitration only matters on conflict; otherwise the lone requester wins.
    always_comb begin
        d_req = d_read | d_write;
        if (i_read && d_req) begin
            grant_d = (DATA_PRIO != 0) ? 1'b1 : !last_d_q;
        end else begin
            grant_d = d_req;
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        state_d  = state_q;
        last_d_d = last_d_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        write_d  = write_q;

        case (state_q)
            IDLE: begin
                if (i_read || d_req) begin
                    last_d_d = grant_d;
                    if (grant_d) begin
                        state_d = D_BUSY;
                        addr_d  = d_address;
                        wdata_d = d_wdata;
                        be_d    = d_byte_enable;
                        write_d = d_write;  // read+write together issues the write only
                    end else begin
                        state_d = I_BUSY;
                        addr_d  = i_address;
                        wdata_d = 32'h0;
                        be_d    = 4'hF;
                        write_d = 1'b0;
                    end
                end
            end
            I_BUSY, D_BUSY: begin
                if (mem_resp) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            be_q     <= 4'h0;
            write_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            write_q  <= write_d;
        end
    end

    // Memory side is driven purely from the latched request, never from live inputs.
    assign mem_read        = (state_q == I_BUSY) || ((state_q == D_BUSY) && !write_q);
    assign mem_write       = (state_q == D_BUSY) && write_q;
    assign mem_address     = addr_q;
    assign mem_wdata       = wdata_q;
    assign mem_byte_enable = be_q;

    assign i_resp  = (state_q == I_BUSY) && mem_resp;
    assign d_resp  = (state_q == D_BUSY) && mem_resp;
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: one fixed-priority and one round-robin instance, with
// a scoreboard of expected memory transactions checked as each grant appears.
module tb_mem_arbiter;

    logic clk;
    logic rst;

    logic        i_read          [2];
    logic [31:0] i_address       [2];
    logic [31:0] i_rdata         [2];
    logic        i_resp          [2];
    logic        d_read          [2];
    logic        d_write         [2];
    logic [3:0]  d_byte_enable   [2];
    logic [31:0] d_address       [2];
    logic [31:0] d_wdata         [2];
    logic [31:0] d_rdata         [2];
    logic        d_resp          [2];
    logic        mem_read        [2];
    logic        mem_write       [2];
    logic [3:0]  mem_byte_enable [2];
    logic [31:0] mem_address     [2];
    logic [31:0] mem_wdata       [2];
    logic [31:0] mem_rdata       [2];
    logic        mem_resp        [2];

    typedef struct {
        bit          is_d;
        bit          write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } txn_t;

    txn_t exp_q[$];
    bit   model_last_d [2];
    int   total;
    int   bad;

    mem_arbiter #(.DATA_PRIO(1)) u_prio (
        .clk(clk), .rst(rst),
        .i_read(i_read[0]), .i_address(i_address[0]), .i_rdata(i_rdata[0]), .i_resp(i_resp[0]),
        .d_read(d_read[0]), .d_write(d_write[0]), .d_byte_enable(d_byte_enable[0]),
        .d_address(d_address[0]), .d_wdata(d_wdata[0]), .d_rdata(d_rdata[0]), .d_resp(d_resp[0]),
        .mem_read(mem_read[0]), .mem_write(mem_write[0]), .mem_byte_enable(mem_byte_enable[0]),
        .mem_address(mem_address[0]), .mem_wdata(mem_wdata[0]),
        .mem_rdata(mem_rdata[0]), .mem_resp(mem_resp[0])
    );

    mem_arbiter #(.DATA_PRIO(0)) u_rr (
        .clk(clk), .rst(rst),
        .i_read(i_read[1]), .i_address(i_address[1]), .i_rdata(i_rdata[1]), .i_resp(i_resp[1]),
        .d_read(d_read[1]), .d_write(d_write[1]), .d_byte_enable(d_byte_enable[1]),
        .d_address(d_address[1]), .d_wdata(d_wdata[1]), .d_rdata(d_rdata[1]), .d_resp(d_resp[1]),
        .mem_read(mem_read[1]), .mem_write(mem_write[1]), .mem_byte_enable(mem_byte_enable[1]),
        .mem_address(mem_address[1]), .mem_wdata(mem_wdata[1]),
        .mem_rdata(mem_rdata[1]), .mem_resp(mem_resp[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference arbitration: returns 1 when data should win given live requests.
    function automatic bit model_grant_d(input int u, input bit i_req, input bit d_req);
        if (i_req && d_req) return (u == 0) ? 1'b1 : !model_last_d[u];
        return d_req;
    endfunction

    function automatic void push_grant(input int u, input bit is_d);
        txn_t t;
        t.is_d = is_d;
        if (is_d) begin
            t.write = d_write[u];
            t.addr  = d_address[u];
            t.wdata = d_wdata[u];
            t.be    = d_byte_enable[u];
        end else begin
            t.write = 1'b0;
            t.addr  = i_address[u];
            t.wdata = 32'h0;
            t.be    = 4'hF;
        end
        model_last_d[u] = is_d;
        exp_q.push_back(t);
    endfunction

    // Waits for the next memory request on instance u, compares it with the
    // scoreboard head, holds it for lat cycles, then responds with rdata.
    task automatic serve(input int u, input int lat, input logic [31:0] rdata,
                         input int exp_wait, input bit poke, input bit keep);
        int   waited;
        txn_t e;
        waited = 0;
        tick();
        while (!(mem_read[u] || mem_write[u]) && waited < 20) begin
            tick();
            waited++;
        end
        check("grant_wait", waited, exp_wait);
        if (exp_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        check("mem_write", mem_write[u], e.write);
        check("mem_read", mem_read[u], !e.write);
        check("mem_address", mem_address[u], e.addr);
        check("mem_wdata", mem_wdata[u], e.wdata);
        check("mem_be", mem_byte_enable[u], e.be);
        for (int k = 0; k < lat; k++) begin
            check("resp_early", {i_resp[u], d_resp[u]}, 32'd0);
            if (poke && k == 0) begin
                d_address[u]     = 32'h200;
                d_wdata[u]       = 32'h5555_AAAA;
                d_byte_enable[u] = 4'h5;
            end
            tick();
            check("addr_hold", mem_address[u], e.addr);
            check("req_hold", {mem_read[u], mem_write[u]}, {!e.write, e.write});
        end
        mem_resp[u]  = 1'b1;
        mem_rdata[u] = rdata;
        #1;
        check("i_resp", i_resp[u], !e.is_d);
        check("d_resp", d_resp[u], e.is_d);
        check("rdata", e.is_d ? d_rdata[u] : i_rdata[u], rdata);
        tick();
        mem_resp[u] = 1'b0;
        if (!keep) begin
            if (e.is_d) begin
                d_read[u]  = 1'b0;
                d_write[u] = 1'b0;
            end else begin
                i_read[u] = 1'b0;
            end
        end
        #1;
        check("idle_req", {mem_read[u], mem_write[u]}, 32'd0);
        check("idle_resp", {i_resp[u], d_resp[u]}, 32'd0);
    endtask

    initial begin
        bit g;
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        for (int u = 0; u < 2; u++) begin
            i_read[u] = 0; i_address[u] = 0; d_read[u] = 0; d_write[u] = 0;
            d_byte_enable[u] = 0; d_address[u] = 0; d_wdata[u] = 0;
            mem_rdata[u] = 0; mem_resp[u] = 0; model_last_d[u] = 0;
        end
        tick();
        tick();
        for (int u = 0; u < 2; u++) begin
            check("rst_req", {mem_read[u], mem_write[u]}, 32'd0);
            check("rst_resp", {i_resp[u], d_resp[u]}, 32'd0);
            check("rst_addr", mem_address[u], 32'h0);
            check("rst_be", mem_byte_enable[u], 32'h0);
        end
        rst = 1'b1;

        // Lone fetch with a three-cycle memory.
        i_address[0] = 32'h60;
        i_read[0]    = 1'b1;
        push_grant(0, model_grant_d(0, 1'b1, 1'b0));
        serve(0, 3, 32'h0000_0013, 0, 1'b0, 1'b0);

        // Fixed-priority conflict: write first, then the fetch.
        i_address[0]     = 32'h80;
        i_read[0]        = 1'b1;
        d_write[0]       = 1'b1;
        d_address[0]     = 32'h100;
        d_wdata[0]       = 32'hDEAD_BEEF;
        d_byte_enable[0] = 4'b0011;
        g = model_grant_d(0, 1'b1, 1'b1);
        push_grant(0, g);
        push_grant(0, !g);
        serve(0, 1, 32'h1111_0000, 0, 1'b0, 1'b0);
        serve(0, 2, 32'h2222_0000, 0, 1'b0, 1'b0);

        // Data inputs wiggle while a fetch is in service.
        i_address[0] = 32'h400;
        i_read[0]    = 1'b1;
        d_address[0] = 32'h100;
        push_grant(0, model_grant_d(0, 1'b1, 1'b0));
        serve(0, 3, 32'h3333_0000, 0, 1'b1, 1'b0);

        // Round-robin with both requesters held across three transactions.
        i_address[1] = 32'h600;
        i_read[1]    = 1'b1;
        d_address[1] = 32'h500;
        d_read[1]    = 1'b1;
        for (int k = 0; k < 3; k++) push_grant(1, model_grant_d(1, 1'b1, 1'b1));
        for (int k = 0; k < 3; k++) serve(1, k, 32'h4444_0000 + k, 0, 1'b0, 1'b1);
        i_read[1] = 1'b0;
        d_read[1] = 1'b0;
        tick();
        tick();
        check("rr_quiet", {mem_read[1], mem_write[1]}, 32'd0);

        // Read and write together issue only the write.
        d_read[1]        = 1'b1;
        d_write[1]       = 1'b1;
        d_address[1]     = 32'h700;
        d_wdata[1]       = 32'h1234_5678;
        d_byte_enable[1] = 4'hC;
        push_grant(1, model_grant_d(1, 1'b0, 1'b1));
        serve(1, 1, 32'h5555_0000, 0, 1'b0, 1'b0);

        // Reset in the middle of a data read.
        d_address[0] = 32'h300;
        d_read[0]    = 1'b1;
        tick();
        check("pre_rst_read", mem_read[0], 1'b1);
        rst       = 1'b0;
        d_read[0] = 1'b0;
        tick();
        rst = 1'b1;
        model_last_d[0] = 1'b0;
        model_last_d[1] = 1'b0;
        #1;
        check("post_rst_read", mem_read[0], 1'b0);
        check("post_rst_dresp", d_resp[0], 1'b0);
        check("post_rst_addr", mem_address[0], 32'h0);
        check("post_rst_wdata", mem_wdata[0], 32'h0);
        mem_resp[0]  = 1'b1;
        mem_rdata[0] = 32'hBAD0_0001;
        #1;
        check("stray_resp", {i_resp[0], d_resp[0]}, 32'd0);
        tick();
        mem_resp[0] = 1'b0;
        #1;
        check("stray_state", {mem_read[0], mem_write[0]}, 32'd0);

        // Round-robin history cleared by reset: data wins the first conflict again.
        i_address[1] = 32'h900;
        i_read[1]    = 1'b1;
        d_address[1] = 32'h800;
        d_read[1]    = 1'b1;
        d_write[1]   = 1'b0;
        g = model_grant_d(1, 1'b1, 1'b1);
        push_grant(1, g);
        push_grant(1, !g);
        serve(1, 0, 32'h6666_0000, 0, 1'b0, 1'b0);
        serve(1, 1, 32'h7777_0000, 0, 1'b0, 1'b0);

        // Read data is a straight pass-through regardless of state.
        mem_rdata[0] = 32'hCAFE_F00D;
        #1;
        check("i_rdata_pass", i_rdata[0], 32'hCAFE_F00D);
        check("d_rdata_pass", d_rdata[0], 32'hCAFE_F00D);

        check("sb_left", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
